// File: rtl/ed25519_bpm_operand_bank_if.sv
// Host register bus plus Ed25519 base-point multiplier core port, shared by the
// operand bank (slave) and whatever drives the host and core sides (master).
interface ed25519_bpm_operand_bank_if;
  logic        host_wr;
  logic        host_rd;
  logic [3:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic        core_ena;
  logic        core_rdy;
  logic [2:0]  core_k_addr;
  logic [31:0] core_k_din;
  logic [2:0]  core_qy_addr;
  logic        core_qy_wren;
  logic [31:0] core_qy_dout;

  modport master (
    output host_wr, host_rd, host_addr, host_wdata, start,
           core_rdy, core_k_addr, core_qy_addr, core_qy_wren, core_qy_dout,
    input  host_rdata, host_rvalid, busy, done, err, core_ena, core_k_din
  );

  modport slave (
    input  host_wr, host_rd, host_addr, host_wdata, start,
           core_rdy, core_k_addr, core_qy_addr, core_qy_wren, core_qy_dout,
    output host_rdata, host_rvalid, busy, done, err, core_ena, core_k_din
  );
endinterface

// File: rtl/ed25519_bpm_operand_bank.sv
// Operand bank for the Ed25519 base-point multiplier: holds scalar K, captures
// result QY, sequences core ena/rdy with a watchdog, and exposes both to the host.
module ed25519_bpm_operand_bank #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TO_W           = 21
) (
  input logic                        clk,
  input logic                        rst_n,
  ed25519_bpm_operand_bank_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     k_mem  [8];
  logic [31:0]     qy_mem [8];
  logic [7:0]      qy_mask;
  logic [TO_W-1:0] wd;
  logic            done_q, err_q, rvalid_q;
  logic [31:0]     rdata_q, k_din_q;
  logic            active, timeout, accept, finish, core_ena;

  assign active  = (state == S_ARM) || (state == S_RUN);
  // A zero TIMEOUT_CYCLES disables the watchdog entirely.
  assign timeout = (TIMEOUT_CYCLES != 0) && active &&
                   (wd == TO_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    core_ena  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start && bus.core_rdy) begin
          state_nxt = S_ARM;
          accept    = 1'b1;
        end
      end
      S_ARM: begin
        core_ena = 1'b1;
        if (timeout) begin
          state_nxt = S_DONE;
          finish    = 1'b1;
          core_ena  = 1'b0;
        end else if (!bus.core_rdy) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (timeout || bus.core_rdy) begin
          state_nxt = S_DONE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: both buffers are cleared on reset so the host never reads stale operands.
      for (int i = 0; i < 8; i++) begin
        k_mem[i]  <= '0;
        qy_mem[i] <= '0;
      end
      qy_mask  <= '0;
      wd       <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      k_din_q  <= '0;
    end else begin
      // K is frozen while the core may be reading it.
      if (bus.host_wr && !bus.host_addr[3] && !active)
        k_mem[bus.host_addr[2:0]] <= bus.host_wdata;

      if (accept) begin
        for (int i = 0; i < 8; i++) qy_mem[i] <= '0;
        qy_mask <= '0;
      end else if (active && bus.core_qy_wren) begin
        qy_mem[bus.core_qy_addr]  <= bus.core_qy_dout;
        qy_mask[bus.core_qy_addr] <= 1'b1;
      end

      if (accept)      wd <= '0;
      else if (active) wd <= wd + 1'b1;

      if (accept) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end else if (finish) begin
        done_q <= 1'b1;
        err_q  <= timeout || (qy_mask != 8'hFF);
      end

      rvalid_q <= bus.host_rd;
      if (bus.host_rd)
        rdata_q <= bus.host_addr[3] ? qy_mem[bus.host_addr[2:0]]
                                    : k_mem[bus.host_addr[2:0]];

      k_din_q <= k_mem[bus.core_k_addr];
    end
  end

  assign bus.busy        = active;
  assign bus.core_ena    = core_ena;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = rdata_q;
  assign bus.core_k_din  = k_din_q;

endmodule

// File: tb/tb_ed25519_bpm_operand_bank.sv
// Scoreboard bench for ed25519_bpm_operand_bank: directed stimulus pushes expected
// read/k_din responses, a negedge monitor pops and compares them.
module tb_ed25519_bpm_operand_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ed25519_bpm_operand_bank_if bus ();

  ed25519_bpm_operand_bank #(.TIMEOUT_CYCLES(50), .TO_W(21)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t rd_q[$];
  exp_t k_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic k_req   = 1'b0;
  logic k_vld   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host_write(input logic [3:0] addr, input logic [31:0] data);
    bus.host_wr    = 1'b1;
    bus.host_addr  = addr;
    bus.host_wdata = data;
    tick();
    bus.host_wr    = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    e.name  = name;
    e.value = exp;
    rd_q.push_back(e);
    bus.host_rd   = 1'b1;
    bus.host_addr = addr;
    tick();
    bus.host_rd   = 1'b0;
  endtask

  task automatic core_read(input logic [2:0] addr, input logic [31:0] exp);
    exp_t e;
    e.name  = "k_din";
    e.value = exp;
    k_q.push_back(e);
    bus.core_k_addr = addr;
    k_req = 1'b1;
    tick();
  endtask

  task automatic core_write(input logic [2:0] addr, input logic [31:0] data);
    bus.core_qy_wren = 1'b1;
    bus.core_qy_addr = addr;
    bus.core_qy_dout = data;
    tick();
    bus.core_qy_wren = 1'b0;
  endtask

  // k_din is valid one edge after its address was presented.
  always @(posedge clk) k_vld <= k_req;

  always @(negedge clk) begin
    exp_t e;
    if (bus.host_rvalid === 1'b1) begin
      if (rd_q.size() == 0) check1("rd_unexpected", bus.host_rvalid, 1'b0);
      else begin
        e = rd_q.pop_front();
        check(e.name, bus.host_rdata, e.value);
      end
    end
    if (k_vld && k_q.size() != 0) begin
      e = k_q.pop_front();
      check(e.name, bus.core_k_din, e.value);
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b1;
    bus.core_rdy     = 1'b1;
    bus.host_wr      = 1'b0;
    bus.host_rd      = 1'b0;
    bus.host_addr    = '0;
    bus.host_wdata   = '0;
    bus.core_k_addr  = '0;
    bus.core_qy_addr = '0;
    bus.core_qy_wren = 1'b0;
    bus.core_qy_dout = '0;

    // Reset held with start asserted
    repeat (3) tick();
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_done", bus.done, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    check1("rst_ena", bus.core_ena, 1'b0);
    check1("rst_rvalid", bus.host_rvalid, 1'b0);
    check("rst_rdata", bus.host_rdata, 32'h0);
    check("rst_k_din", bus.core_k_din, 32'h0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    check1("idle_busy", bus.busy, 1'b0);

    // Normal run
    for (int i = 0; i < 8; i++) host_write(4'(i), 32'(i + 1));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check1("arm_busy", bus.busy, 1'b1);
    check1("arm_ena", bus.core_ena, 1'b1);
    tick();
    bus.core_rdy = 1'b0;
    tick();
    check1("run_ena", bus.core_ena, 1'b0);
    check1("run_busy", bus.busy, 1'b1);
    for (int i = 0; i < 8; i++) core_read(3'(i), 32'(i + 1));
    k_req = 1'b0;
    for (int i = 0; i < 8; i++) core_write(3'(i), 32'hA0 + 32'(i));
    bus.core_rdy = 1'b1;
    tick();
    check1("norm_done", bus.done, 1'b1);
    check1("norm_err", bus.err, 1'b0);
    check1("norm_busy", bus.busy, 1'b0);
    for (int i = 0; i < 8; i++) host_read(4'(8 + i), 32'hA0 + 32'(i), "norm_qy");
    for (int i = 0; i < 8; i++) host_read(4'(i), 32'(i + 1), "norm_k");

    // Partial result, protection, same-cycle start and K write
    bus.start = 1'b1;
    host_write(4'h0, 32'h11);
    bus.start = 1'b0;
    check1("part_done_clr", bus.done, 1'b0);
    check1("part_err_clr", bus.err, 1'b0);
    check1("part_busy", bus.busy, 1'b1);
    host_write(4'h3, 32'hDEAD);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check1("restart_busy", bus.busy, 1'b1);
    check1("restart_done", bus.done, 1'b0);
    bus.core_rdy = 1'b0;
    tick();
    core_read(3'd0, 32'h11);
    core_read(3'd3, 32'h4);
    k_req = 1'b0;
    for (int i = 0; i < 7; i++) core_write(3'(i), 32'hB0 + 32'(i));
    bus.core_rdy = 1'b1;
    tick();
    check1("part_done", bus.done, 1'b1);
    check1("part_err", bus.err, 1'b1);
    host_read(4'h3, 32'h4, "prot_k3");
    host_read(4'h8, 32'hB0, "part_qy0");
    host_read(4'hF, 32'h0, "part_qy7");
    host_read(4'h0, 32'h11, "same_cycle_k0");
    core_write(3'd0, 32'h1234);
    host_read(4'h8, 32'hB0, "idle_wren");
    host_write(4'h8, 32'hFFFF);
    host_read(4'h8, 32'hB0, "qy_host_wr");

    // Timeout: core never drops rdy
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check1("to_done_clr", bus.done, 1'b0);
    for (int k = 1; k < 50; k++) tick();
    check1("to_busy_49", bus.busy, 1'b1);
    check1("to_done_49", bus.done, 1'b0);
    tick();
    check1("to_done", bus.done, 1'b1);
    check1("to_err", bus.err, 1'b1);
    check1("to_ena", bus.core_ena, 1'b0);
    check1("to_busy", bus.busy, 1'b0);

    // Reset mid-run
    bus.start = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.core_rdy = 1'b0;
    tick();
    check1("mid_busy", bus.busy, 1'b1);
    core_write(3'd1, 32'h55);
    rst_n = 1'b0;
    tick();
    check1("mid_rst_busy", bus.busy, 1'b0);
    check1("mid_rst_done", bus.done, 1'b0);
    check1("mid_rst_ena", bus.core_ena, 1'b0);
    rst_n        = 1'b1;
    bus.core_rdy = 1'b1;
    host_read(4'h0, 32'h0, "mid_rst_k0");
    host_read(4'h9, 32'h0, "mid_rst_qy1");
    repeat (2) tick();

    check(32'(rd_q.size()) == 0 ? "rd_q_drained" : "rd_q_drained", 32'(rd_q.size()), 32'h0);
    check("k_q_drained", 32'(k_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
